// File: rtl/dbg_capture_pkg.sv
// dbg_capture_pkg: state encoding, trigger modes and sizing helper shared by dbg_capture
package dbg_capture_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    READ  = 3'd5
  } state_t;
  localparam logic [1:0] MODE_MATCH  = 2'd0;
  localparam logic [1:0] MODE_CHANGE = 2'd1;
  localparam logic [1:0] MODE_IMM    = 2'd2;
  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/dbg_capture_ram.sv
// dbg_capture_ram: simple dual-port sample buffer, one write port and one enabled synchronous read port
module dbg_capture_ram
  import dbg_capture_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int W = 25,
  localparam int AW = aw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dbg_capture.sv
// dbg_capture: logic-analyser capture core with masked trigger, pre-trigger window and valid/ready readout
// Define DBG_CAPTURE_TSTAMP_EN to store a TS_W-bit cycle stamp with every sample and expose it on rd_ts.
module dbg_capture
  import dbg_capture_pkg::*;
#(
  parameter int DATA_W = 25,
  parameter int TRIG_W = 3,
  parameter int DEPTH = 256,
`ifdef DBG_CAPTURE_TSTAMP_EN
  parameter int TS_W = 16,
`endif
  localparam int AW = aw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [TRIG_W-1:0] trig_value,
  input  logic [TRIG_W-1:0] trig_mask,
  input  logic [1:0]        trig_mode,
  input  logic [AW-1:0]     pre_count,
  input  logic              arm,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              done,
`ifdef DBG_CAPTURE_TSTAMP_EN
  output logic [TS_W-1:0]   rd_ts,
`endif
  output logic [2:0]        state_o
);
`ifdef DBG_CAPTURE_TSTAMP_EN
  localparam int MW = DATA_W + TS_W;
`else
  localparam int MW = DATA_W;
`endif
  state_t state;
  logic [AW-1:0] wptr, rptr, pre_q, pcnt, post_cnt, trig_addr;
  logic [AW:0] remain;
  logic [TRIG_W-1:0] trig_q, value_q, mask_q;
  logic [1:0] mode_q;
  logic first_armed, fire, match, change, issue, arm_ok;
  logic ram_v, ram_last, skid_v, skid_last;
  logic [MW-1:0] wdata, rdata, skid_d, word;
  assign busy = state inside {PRE, ARMED, POST};
  assign state_o = state;
  assign arm_ok = arm && (state == IDLE || state == DONE);
  assign match = ((trig_i ^ value_q) & mask_q) == '0;
  assign change = ((trig_i ^ trig_q) & mask_q) != '0;
  assign fire = mode_q == MODE_IMM ? first_armed :
                mode_q == MODE_CHANGE ? change && !first_armed : match;
  // reads are only issued while the skid is empty, so the skid can always absorb one stalled word
  assign issue = state == READ && remain != '0 && !skid_v;
  assign word = skid_v ? skid_d : ram_v ? rdata : '0;
  assign rd_valid = skid_v | ram_v;
  assign rd_last = skid_v ? skid_last : ram_v & ram_last;
  assign rd_data = word[DATA_W-1:0];
`ifdef DBG_CAPTURE_TSTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk) ts <= (rst || arm_ok) ? '0 : ts + 1'b1;
  assign wdata = {ts, data_i};
  assign rd_ts = word[MW-1:DATA_W];
`else
  assign wdata = data_i;
`endif
  dbg_capture_ram #(.DEPTH(DEPTH), .W(MW)) u_ram (
    .clk(clk),
    .we(busy),
    .waddr(wptr),
    .wdata(wdata),
    .re(issue),
    .raddr(rptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    trig_q <= trig_i;
    if (!skid_v && ram_v && !rd_ready) skid_d <= rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      pre_q <= '0;
      pcnt <= '0;
      post_cnt <= '0;
      trig_addr <= '0;
      remain <= '0;
      value_q <= '0;
      mask_q <= '0;
      mode_q <= MODE_MATCH;
      first_armed <= 1'b0;
      triggered <= 1'b0;
      done <= 1'b0;
      ram_v <= 1'b0;
      ram_last <= 1'b0;
      skid_v <= 1'b0;
      skid_last <= 1'b0;
    end else begin
      if (busy) wptr <= wptr + 1'b1;
      if (issue) begin
        rptr <= rptr + 1'b1;
        remain <= remain - 1'b1;
        ram_last <= remain == (AW+1)'(1);
      end
      ram_v <= issue | (skid_v & ram_v);
      if (!skid_v && ram_v && !rd_ready) begin
        skid_v <= 1'b1;
        skid_last <= ram_last;
      end else if (skid_v && rd_ready) skid_v <= 1'b0;
      case (state)
        IDLE, DONE:
          if (arm) begin
            pre_q <= pre_count;
            value_q <= trig_value;
            mask_q <= trig_mask;
            mode_q <= trig_mode;
            first_armed <= 1'b1;
            triggered <= 1'b0;
            done <= 1'b0;
            wptr <= '0;
            pcnt <= '0;
            state <= pre_count != '0 ? PRE : ARMED;
          end else if (state == DONE && rd_start) begin
            rptr <= trig_addr - pre_q;
            remain <= (AW+1)'(DEPTH);
            state <= READ;
          end
        PRE: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == pre_q - 1'b1) state <= ARMED;
        end
        ARMED: begin
          first_armed <= 1'b0;
          if (fire) begin
            trig_addr <= wptr;
            triggered <= 1'b1;
            post_cnt <= AW'(DEPTH - 1) - pre_q;
            state <= pre_q == AW'(DEPTH - 1) ? DONE : POST;
            done <= pre_q == AW'(DEPTH - 1);
          end
        end
        POST: begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == AW'(1)) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        READ: if (rd_valid && rd_ready && rd_last) state <= READ == READ ? DONE : READ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_capture.sv
// tb_dbg_capture: directed bench with a window-level capture model and a per-cycle readout checker
module tb_dbg_capture;
  localparam int DW = 8, TW = 3, D = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic [TW-1:0] trig_i = '0, trig_value = '0, trig_mask = '0;
  logic [1:0] trig_mode = '0;
  logic [3:0] pre_count = '0;
  logic arm = 1'b0, rd_start = 1'b0, rd_ready = 1'b0;
  logic rd_valid, rd_last, busy, triggered, done;
  logic [DW-1:0] rd_data;
  logic [2:0] state_o;
  int errors = 0, checks = 0;
  int log_d[$], log_t[$];
  bit logging = 1'b0, reading = 1'b0;
  int m_pre, m_mode, m_mask, m_val;
  int exp_win[D];
  int rd_idx, first_rx, last_rx;

  dbg_capture #(.DATA_W(DW), .TRIG_W(TW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .trig_i(trig_i), .trig_value(trig_value),
    .trig_mask(trig_mask), .trig_mode(trig_mode), .pre_count(pre_count), .arm(arm),
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .triggered(triggered), .done(done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    data_i = data_i + 8'd1;
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 300 && int'(data_i) != n; i++) tick();
  endtask

  always @(posedge clk) if (logging) begin
    log_d.push_back(int'(data_i));
    log_t.push_back(int'(trig_i));
  end

  // Readout checker: each offered word must be the next one of the expected window.
  always @(negedge clk) if (reading && rd_valid) begin
    if (rd_idx < D) begin
      chk("rd_data", int'(rd_data), exp_win[rd_idx]);
      chk("rd_last", int'(rd_last), int'(rd_idx == D - 1));
      if (rd_ready) begin
        if (rd_idx == 0) first_rx = int'(rd_data);
        last_rx = int'(rd_data);
        rd_idx++;
      end
    end else chk("rd_extra_valid", int'(rd_valid), 0);
  end

  // Log index 0 is the arm edge; PRE fills 1..pre, the trigger is searched from pre+1 onward.
  task automatic model();
    int t = -1;
    for (int i = m_pre + 1; i < log_t.size() && t < 0; i++) begin
      bit hit;
      if (m_mode == 2) hit = (i == m_pre + 1);
      else if (m_mode == 1) hit = (i != m_pre + 1) && (((log_t[i] ^ log_t[i-1]) & m_mask) != 0);
      else hit = ((log_t[i] ^ m_val) & m_mask) == 0;
      if (hit) t = i;
    end
    chk("model_window_found", int'(t >= 0 && t + D - 1 - m_pre < log_d.size()), 1);
    for (int k = 0; k < D; k++)
      exp_win[k] = (t >= 0 && t - m_pre + k < log_d.size()) ? log_d[t - m_pre + k] : -1;
  endtask

  task automatic do_arm(input int pre, input int mode, input int mask, input int val);
    pre_count = 4'(pre);
    trig_mode = 2'(mode);
    trig_mask = 3'(mask);
    trig_value = 3'(val);
    m_pre = pre;
    m_mode = mode;
    m_mask = mask;
    m_val = val;
    log_d.delete();
    log_t.delete();
    logging = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(output bit saw_post);
    saw_post = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (state_o == 3'd3) saw_post = 1'b1;
      tick();
    end
    chk("done_reached", int'(done), 1);
    logging = 1'b0;
    model();
  endtask

  task automatic read_out(input bit bp);
    int n = 0;
    rd_idx = 0;
    first_rx = -1;
    last_rx = -1;
    reading = 1'b1;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("rd_valid_after_start", int'(rd_valid), 0);
    chk("state_read", int'(state_o), 5);
    tick();
    chk("rd_valid_latency", int'(rd_valid), 1);
    while (rd_idx < D && n < 200) begin
      rd_ready = bp ? (n % 4 == 0 || n % 4 == 3) : 1'b1;
      tick();
      n++;
    end
    chk("rd_count", rd_idx, D);
    chk("rd_valid_end", int'(rd_valid), 0);
    chk("state_back_done", int'(state_o), 4);
    chk("done_kept", int'(done), 1);
    reading = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    bit sp;
    repeat (3) tick();
    chk("rst_state", int'(state_o), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_last", int'(rd_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_triggered", int'(triggered), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    data_i = '0;
    // match trigger with a 4-sample pre-window
    run_to(10);
    do_arm(4, 0, 7, 5);
    chk("t1_state_pre", int'(state_o), 1);
    chk("t1_busy", int'(busy), 1);
    run_to(20);
    trig_i = 3'd5;
    tick();
    trig_i = 3'd0;
    wait_done(sp);
    chk("t1_triggered", int'(triggered), 1);
    chk("t1_busy_off", int'(busy), 0);
    chk("t1_post_seen", int'(sp), 1);
    chk("t1_model_first", exp_win[0], 16);
    chk("t1_model_last", exp_win[D-1], 31);
    read_out(1'b0);
    chk("t1_first", first_rx, 16);
    chk("t1_last", last_rx, 31);
    // a match inside the pre-window is ignored; readout under backpressure, then re-read
    data_i = '0;
    do_arm(4, 0, 7, 5);
    trig_i = 3'd5;
    tick();
    trig_i = 3'd0;
    chk("t2_still_pre", int'(state_o), 1);
    chk("t2_not_triggered", int'(triggered), 0);
    run_to(40);
    trig_i = 3'd5;
    tick();
    trig_i = 3'd0;
    wait_done(sp);
    chk("t2_model_first", exp_win[0], 36);
    chk("t2_model_last", exp_win[D-1], 51);
    read_out(1'b1);
    chk("t2_first", first_rx, 36);
    chk("t2_last", last_rx, 51);
    read_out(1'b1);
    chk("t2_reread_first", first_rx, 36);
    chk("t2_reread_last", last_rx, 51);
    // change mode, masked bit0 toggle is ignored, bit1 toggle fires, no pre-window
    data_i = '0;
    trig_i = 3'd0;
    run_to(5);
    do_arm(0, 1, 2, 0);
    run_to(10);
    trig_i = 3'd1;
    run_to(25);
    trig_i = 3'd3;
    wait_done(sp);
    trig_i = 3'd0;
    chk("t3_model_first", exp_win[0], 25);
    read_out(1'b0);
    chk("t3_first", first_rx, 25);
    chk("t3_last", last_rx, 40);
    // immediate mode with maximum pre-window: trigger is the last sample, no POST
    data_i = 8'd100;
    do_arm(15, 2, 0, 0);
    wait_done(sp);
    chk("t4_no_post", int'(sp), 0);
    chk("t4_triggered", int'(triggered), 1);
    chk("t4_model_last", exp_win[D-1], 116);
    read_out(1'b0);
    chk("t4_first", first_rx, 101);
    chk("t4_last", last_rx, 116);
    // mode 3 with an all-zero mask fires on the first ARMED cycle
    data_i = '0;
    do_arm(2, 3, 0, 5);
    wait_done(sp);
    read_out(1'b0);
    chk("t5_first", first_rx, 1);
    chk("t5_last", last_rx, 16);
    // arm while ARMED is ignored
    data_i = '0;
    trig_i = 3'd0;
    do_arm(0, 0, 7, 6);
    repeat (3) tick();
    chk("t6_armed", int'(state_o), 2);
    pre_count = 4'd8;
    trig_mode = 2'd2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t6_arm_ignored", int'(state_o), 2);
    run_to(30);
    trig_i = 3'd6;
    tick();
    trig_i = 3'd0;
    wait_done(sp);
    read_out(1'b0);
    chk("t6_first", first_rx, 30);
    chk("t6_last", last_rx, 45);
    // arm and rd_start together in DONE: arm wins; then reset mid-POST
    pre_count = 4'd3;
    arm = 1'b1;
    rd_start = 1'b1;
    tick();
    arm = 1'b0;
    rd_start = 1'b0;
    chk("t7_arm_wins", int'(state_o), 1);
    chk("t7_done_cleared", int'(done), 0);
    chk("t7_rd_valid", int'(rd_valid), 0);
    for (int i = 0; i < 40 && state_o != 3'd3; i++) tick();
    chk("t7_in_post", int'(state_o), 3);
    rst = 1'b1;
    tick();
    chk("t7_rst_state", int'(state_o), 0);
    chk("t7_rst_done", int'(done), 0);
    chk("t7_rst_triggered", int'(triggered), 0);
    chk("t7_rst_busy", int'(busy), 0);
    rst = 1'b0;
    // reset mid-READ
    data_i = '0;
    do_arm(0, 2, 0, 0);
    wait_done(sp);
    rd_idx = 0;
    reading = 1'b1;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    chk("t8_reading", int'(rd_valid), 1);
    reading = 1'b0;
    rst = 1'b1;
    tick();
    chk("t8_rst_state", int'(state_o), 0);
    chk("t8_rst_rd_valid", int'(rd_valid), 0);
    chk("t8_rst_rd_data", int'(rd_data), 0);
    chk("t8_rst_done", int'(done), 0);
    rst = 1'b0;
    rd_ready = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
